// File: rtl/nr_pkg.sv
// Shared definitions for the flag unit: flag bit positions, condition codes,
// default stack depth and the small decode helpers used by the top level.
package nr_pkg;

  localparam int NR_DEPTH_DEFAULT = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_CS = 3'd3,
    COND_CC = 3'd4,
    COND_MI = 3'd5,
    COND_VS = 3'd6,
    COND_NV = 3'd7
  } cond_e;

  function automatic logic [3:0] alu_flags(input logic n, input logic nz,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = ~nz;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  function automatic logic cond_take(input cond_e c, input logic [3:0] f);
    logic t;
    t = 1'b0;
    case (c)
      COND_AL: t = 1'b1;
      COND_EQ: t = f[FLAG_Z];
      COND_NE: t = ~f[FLAG_Z];
      COND_CS: t = f[FLAG_C];
      COND_CC: t = ~f[FLAG_C];
      COND_MI: t = f[FLAG_N];
      COND_VS: t = f[FLAG_V];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/nr_flag_stack.sv
// LIFO of saved flag words. Occupancy counter has no wrap-around; entries
// themselves are never reset because they are unreadable while empty.
module nr_flag_stack
  import nr_pkg::*;
#(
  parameter int DEPTH = NR_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty,
  output logic       ovf,
  output logic       unf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Simultaneous push and pop cancel out and are not error events.
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign ovf     = push & ~pop & full;
  assign unf     = pop & ~push & empty;

  assign top_idx = count_q - CW'(1);
  assign dout    = empty ? 4'b0000 : mem_q[top_idx[AW-1:0]];

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[count_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/nr_flag_unit.sv
// Condition-flag register with direct write, ALU update, save/restore stack,
// sticky stack error and condition decode.
module nr_flag_unit
  import nr_pkg::*;
#(
  parameter int DEPTH = NR_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] res,
  input  logic       cmp_in,
  input  logic       cin,
  input  logic       vin,
  input  logic       upd,
  input  logic       wr,
  input  logic [3:0] wdata,
  input  logic       push,
  input  logic       pop,
  input  logic       err_clr,
  input  logic [2:0] cond,
  output logic [3:0] flags,
  output logic       take,
  output logic       full,
  output logic       empty,
  output logic       err
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       err_q;
  logic       err_d;
  logic [3:0] alu_f;
  logic [3:0] stk_dout;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_ovf;
  logic       stk_unf;
  logic       pop_ok;

  // Only the sign bit of the result matters; zero comes from the compactor.
  logic unused_res;
  assign unused_res = &{1'b0, res[6:0]};

  assign alu_f  = alu_flags(res[7], cmp_in, cin, vin);
  assign pop_ok = pop & ~push & ~stk_empty;

  nr_flag_stack #(
    .DEPTH(DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (flags_q),
    .dout (stk_dout),
    .full (stk_full),
    .empty(stk_empty),
    .ovf  (stk_ovf),
    .unf  (stk_unf)
  );

  always_comb begin
    flags_d = flags_q;
    if (pop_ok) begin
      flags_d = stk_dout;
    end else if (wr) begin
      flags_d = wdata;
    end else if (upd) begin
      flags_d = alu_f;
    end
  end

  // A new error event in the same cycle as the clear must leave err set.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (stk_ovf || stk_unf) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign flags = flags_q;
  assign err   = err_q;
  assign full  = stk_full;
  assign empty = stk_empty;
  assign take  = cond_take(cond_e'(cond), flags_q);

endmodule

// File: doc/nr_flag_unit.md
NR_FLAG_UNIT -- requirements
Module: nr_flag_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of entries in the flag save stack (range 2..16).
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 res  input  8  ALU result.
REQ-005 cmp_in  input  1  OR-reduction of res from the bit compactor stage; Z = ~cmp_in.
REQ-006 cin / vin  input  1 each  ALU carry-out / signed overflow.
REQ-007 upd  input  1  latch N,Z,C,V from the ALU this cycle.
REQ-008 wr / wdata  input  1 / 4  direct flag write {N,Z,C,V}, sourced from the 4-bit immediate path.
REQ-009 push / pop  input  1 each  save current flags to the stack / restore flags from the stack.
REQ-010 err_clr  input  1  clear the sticky error.
REQ-011 cond  input  3  condition select.
REQ-012 flags  output  4  registered {N,Z,C,V}.
REQ-013 take  output  1  condition result, combinational from flags and cond.
REQ-014 full / empty  output  1 each  stack occupancy status.
REQ-015 err  output  1  sticky stack overflow/underflow.

Function
REQ-016 The block SHALL form ALU flags as N=res[7], Z=~cmp_in, C=cin, V=vin.
REQ-017 On upd, flags SHALL take the ALU flags at the next rising edge, giving one cycle latency.
REQ-018 Flag-register source priority SHALL be: valid pop > wr > upd > hold.
REQ-019 A push SHALL store the flags value present before the current edge, so a same-cycle wr or upd still updates flags.
REQ-020 A valid pop SHALL load flags from the top entry and decrement occupancy.
REQ-021 push and pop in the same cycle SHALL be a no-op for the stack and SHALL NOT set err; wr and upd still apply.
REQ-022 A push when full SHALL be dropped: stack unchanged, err set.
REQ-023 A pop when empty SHALL leave the stack unchanged and set err; wr and upd still apply.
REQ-024 full SHALL equal (count==DEPTH); empty SHALL equal (count==0); both are registered-state derived.
REQ-025 err SHALL be set by REQ-022/023 and cleared only by err_clr or reset; a set event in the same cycle as err_clr SHALL win.
REQ-026 take SHALL decode cond as follows: 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 V; 7 never.
REQ-027 The stack SHALL be LIFO, with the pointer held in ceil(log2(DEPTH+1)) bits and no wrap-around.

Reset
REQ-028 While rst_n=0, the block SHALL force flags=4'b0000, count=0 (empty=1, full=0) and err=0 immediately, independent of clk.
REQ-029 Stack entry contents SHALL NOT be reset; they are unobservable while empty.
REQ-030 Reset asserted mid-operation SHALL abandon any in-progress push/pop, with no partial update after release.

Structure
REQ-031 Package nr_pkg SHALL hold the flag bit indices (N=3, Z=2, C=1, V=0), the cond encodings, and the DEPTH default.
REQ-032 The LIFO SHALL be a sub-module nr_flag_stack with push, pop, din[3:0], dout[3:0], full, empty, ovf and unf; nr_flag_unit holds the flag register, priority logic, err and the cond decode.

Verification
REQ-033 Reset -> flags=0000, empty=1, full=0, err=0; cond=0 gives take=1, and cond=7 gives take=0.
REQ-034 upd with res=8'h80, cmp_in=1, cin=1, vin=0 -> next cycle flags=1010; cond=3 gives take=1, cond=2 gives take=1.
REQ-035 upd with res=8'h00, cmp_in=0, cin=0, vin=1 -> flags=0101; cond=1 gives take=1, cond=4 gives take=1.
REQ-036 Stack test:
- push the values 0001, 0010, 0100, 1000 (DEPTH=4) -> full=1.
- 5th push -> err=1, contents unchanged.
- 4 pops -> 1000, 0100, 0010, 0001.
- 5th pop -> err=1, flags unchanged.
REQ-037 Same-cycle priority tests:
- flags=0011, push with wr and wdata=1100 -> flags=1100; a later pop restores 0011.
- pop with upd in the same cycle -> the popped value wins.
REQ-038 Async reset test: assert rst_n=0 mid-cycle with count=3 and err=1 -> all outputs reach reset values before the next edge; the first push after release lands at entry 0.
